// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for the RV32I pipeline: a shadow copy of
// the in-flight destination info drives operand bypass, load-use bubbles and write-back.
module pipe_hazard_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [4:0]            id_rd_addr,
  input  logic                  id_rf_wen,
  input  logic                  id_is_load,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0] stage_result,
  input  logic                  ex_jump_flag,
  input  logic                  hold,
  output logic [XLEN-1:0]       op1_data,
  output logic [XLEN-1:0]       op2_data,
  output logic [SEL_W-1:0]      rs1_fwd_sel,
  output logic [SEL_W-1:0]      rs2_fwd_sel,
  output logic                  stall,
  output logic                  id_ready,
  output logic                  flush_id,
  output logic                  wb_en,
  output logic [4:0]            wb_addr,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic [DEPTH:1]      v_q, v_d, wen_q, wen_d, ld_q, ld_d;
  logic [DEPTH:1][4:0] rd_q, rd_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                lu1, lu2, lu_stall;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    rs1_fwd_sel = '0;
    rs2_fwd_sel = '0;
    op1_data    = rf_rs1_data;
    op2_data    = rf_rs2_data;
    lu1         = 1'b0;
    lu2         = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && id_rs1_used && (id_rs1_addr != 5'd0) && v_q[k] && wen_q[k] &&
          (rd_q[k] == id_rs1_addr)) begin
        rs1_fwd_sel = SEL_W'(k);
        op1_data    = stage_result[(k-1)*XLEN +: XLEN];
        lu1         = ld_q[k] && (k < LOAD_AVAIL);
      end
      if (id_valid && id_rs2_used && (id_rs2_addr != 5'd0) && v_q[k] && wen_q[k] &&
          (rd_q[k] == id_rs2_addr)) begin
        rs2_fwd_sel = SEL_W'(k);
        op2_data    = stage_result[(k-1)*XLEN +: XLEN];
        lu2         = ld_q[k] && (k < LOAD_AVAIL);
      end
    end
  end

  // hold dominates everything; a taken jump kills decode and masks any load-use.
  assign flush_id = ~hold & ex_jump_flag & v_q[1];
  assign lu_stall = ~hold & ~flush_id & (lu1 | lu2);
  assign stall    = hold | lu_stall;
  assign id_ready = ~stall;
  assign wb_en    = v_q[DEPTH] & wen_q[DEPTH];
  assign wb_addr  = rd_q[DEPTH];

  always_comb begin
    v_d         = v_q;
    wen_d       = wen_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]   = v_q[k-1];
        wen_d[k] = wen_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      v_d[1]   = id_valid & ~stall & ~flush_id;
      wen_d[1] = id_rf_wen;
      ld_d[1]  = id_is_load;
      rd_d[1]  = id_rd_addr;
    end
    if (lu_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_id && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      wen_q       <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wen_q       <= wen_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a behavioural shadow-pipeline model produces expected
// outputs per cycle into a queue; a 4-bit-counter instance covers saturation.
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 32, DEPTH = 3, LA = 2, SW = 2;

  logic clk = 1'b0;
  logic reset, id_valid, id_rs1_used, id_rs2_used, id_rf_wen, id_is_load;
  logic ex_jump_flag, hold;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic [DEPTH*XLEN-1:0] stage_result;

  logic [XLEN-1:0] op1_data, op2_data, s_op1_data, s_op2_data;
  logic [SW-1:0]   rs1_fwd_sel, rs2_fwd_sel, s_rs1_fwd_sel, s_rs2_fwd_sel;
  logic            stall, id_ready, flush_id, wb_en, s_stall, s_id_ready, s_flush_id, s_wb_en;
  logic [4:0]      wb_addr, s_wb_addr;
  logic [31:0]     stall_cnt, flush_cnt;
  logic [3:0]      s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_AVAIL(LA), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .stage_result(stage_result),
    .ex_jump_flag(ex_jump_flag), .hold(hold), .op1_data(op1_data), .op2_data(op2_data),
    .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel), .stall(stall), .id_ready(id_ready),
    .flush_id(flush_id), .wb_en(wb_en), .wb_addr(wb_addr), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt));

  pipe_hazard_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .LOAD_AVAIL(LA), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rf_wen(id_rf_wen), .id_is_load(id_is_load),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .stage_result(stage_result),
    .ex_jump_flag(ex_jump_flag), .hold(hold), .op1_data(s_op1_data), .op2_data(s_op2_data),
    .rs1_fwd_sel(s_rs1_fwd_sel), .rs2_fwd_sel(s_rs2_fwd_sel), .stall(s_stall),
    .id_ready(s_id_ready), .flush_id(s_flush_id), .wb_en(s_wb_en), .wb_addr(s_wb_addr),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  typedef struct {
    int          sel1, sel2;
    logic [31:0] op1, op2;
    logic        stall, flush, wb_en;
    logic [4:0]  wb_addr;
    longint      scnt, fcnt, scnt4;
  } exp_t;
  exp_t exp_q[$];

  logic       mv[1:DEPTH], mwen[1:DEPTH], mld[1:DEPTH];
  logic [4:0] mrd[1:DEPTH];
  longint     mscnt, mfcnt;
  int n_chk = 0, n_err = 0, cyc = 0;
  int last_sel1, last_sel2;
  logic last_stall, last_flush, last_op1_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ymatch(input logic [4:0] a, input logic used);
    if (!id_valid || !used || a == 5'd0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (mv[k] && mwen[k] && mrd[k] == a) return k;
    return 0;
  endfunction

  function automatic logic is_lu(input int k);
    if (k == 0) return 1'b0;
    return mld[k] && (k < LA);
  endfunction

  task automatic step(input logic vld, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic wen, input logic ld, input logic jmp, input logic hld,
                      input logic rst);
    exp_t e, o;
    int k1, k2;
    logic fl, st;
    @(negedge clk);
    cyc++;
    id_valid = vld; id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2;
    id_rs2_used = u2; id_rd_addr = rd; id_rf_wen = wen; id_is_load = ld;
    ex_jump_flag = jmp; hold = hld; reset = rst;
    rf_rs1_data = $urandom; rf_rs2_data = $urandom;
    stage_result = {32'h3000_0000 + 32'(cyc), 32'h2000_0000 + 32'(cyc), 32'h1000_0000 + 32'(cyc)};
    k1 = ymatch(rs1, u1);
    k2 = ymatch(rs2, u2);
    fl = !hld && jmp && mv[1];
    st = hld || (!fl && (is_lu(k1) || is_lu(k2)));
    e.sel1 = k1; e.sel2 = k2;
    e.op1 = (k1 == 0) ? rf_rs1_data : stage_result[32*k1-1 -: 32];
    e.op2 = (k2 == 0) ? rf_rs2_data : stage_result[32*k2-1 -: 32];
    e.stall = st; e.flush = fl;
    e.wb_en = mv[DEPTH] && mwen[DEPTH]; e.wb_addr = mrd[DEPTH];
    e.scnt = mscnt; e.fcnt = mfcnt; e.scnt4 = (mscnt > 15) ? 15 : mscnt;
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    chk("rs1_fwd_sel", 64'(rs1_fwd_sel), 64'(o.sel1));
    chk("rs2_fwd_sel", 64'(rs2_fwd_sel), 64'(o.sel2));
    chk("op1_data", 64'(op1_data), 64'(o.op1));
    chk("op2_data", 64'(op2_data), 64'(o.op2));
    chk("stall", 64'(stall), 64'(o.stall));
    chk("id_ready", 64'(id_ready), 64'(!o.stall));
    chk("flush_id", 64'(flush_id), 64'(o.flush));
    chk("wb_en", 64'(wb_en), 64'(o.wb_en));
    if (o.wb_en) chk("wb_addr", 64'(wb_addr), 64'(o.wb_addr));
    chk("stall_cnt", 64'(stall_cnt), 64'(o.scnt));
    chk("flush_cnt", 64'(flush_cnt), 64'(o.fcnt));
    chk("sat_stall_cnt", 64'(s_stall_cnt), 64'(o.scnt4));
    last_sel1 = int'(rs1_fwd_sel); last_sel2 = int'(rs2_fwd_sel);
    last_stall = stall; last_flush = flush_id;
    last_op1_ok = (op1_data === stage_result[31:0]);
    @(posedge clk);
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) mv[k] = 1'b0;
      mscnt = 0; mfcnt = 0;
    end else if (!hld) begin
      for (int k = DEPTH; k >= 2; k--) begin
        mv[k] = mv[k-1]; mwen[k] = mwen[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
      end
      mv[1] = vld && !st && !fl; mwen[1] = wen; mld[1] = ld; mrd[1] = rd;
      if (st) mscnt++;
      if (fl) mfcnt++;
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd_addr = 0; id_rf_wen = 0; id_is_load = 0; ex_jump_flag = 0;
    hold = 0; rf_rs1_data = 0; rf_rs2_data = 0; stage_result = '0;
    for (int k = 1; k <= DEPTH; k++) begin mv[k] = 0; mwen[k] = 0; mld[k] = 0; mrd[k] = 0; end
    mscnt = 0; mfcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_en", 64'(wb_en), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);

    // back-to-back ALU dependency
    step(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    step(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, 0);
    chk("alu_fwd_sel", 64'(last_sel1), 64'd1);
    chk("alu_fwd_op1", 64'(last_op1_ok), 64'd1);
    chk("alu_no_stall", 64'(last_stall), 64'd0);

    // load-use: one bubble, then both operands from stage 2
    step(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0);
    step(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 0);
    chk("lu_stall", 64'(last_stall), 64'd1);
    #1 chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    step(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 0);
    chk("lu_sel1", 64'(last_sel1), 64'd2);
    chk("lu_sel2", 64'(last_sel2), 64'd2);
    chk("lu_released", 64'(last_stall), 64'd0);

    // youngest wins; x0 never forwarded even if written
    step(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0);
    step(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    step(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 0, 0, 0, 0);
    step(1, 5'd3, 1, 5'd0, 1, 5'd13, 1, 0, 0, 0, 0);
    chk("young_sel1", 64'(last_sel1), 64'd1);
    chk("x0_sel2", 64'(last_sel2), 64'd0);

    // flush wins over load-use
    step(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 1, 0, 0, 0);
    step(1, 5'd10, 1, 5'd0, 0, 5'd11, 1, 0, 1, 0, 0);
    chk("flush_set", 64'(last_flush), 64'd1);
    chk("flush_no_stall", 64'(last_stall), 64'd0);
    #1 chk("flush_cnt1", 64'(flush_cnt), 64'd1);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd1);
    step(1, 5'd11, 1, 5'd10, 1, 5'd15, 1, 0, 0, 0, 0);
    chk("flushed_not_fwd", 64'(last_sel1), 64'd0);
    chk("post_flush_sel2", 64'(last_sel2), 64'd2);

    // hold freezes everything, jump ignored
    repeat (3) begin
      step(1, 5'd15, 1, 5'd0, 0, 5'd16, 1, 0, 1, 1, 0);
      chk("hold_stall", 64'(last_stall), 64'd1);
      chk("hold_no_flush", 64'(last_flush), 64'd0);
    end
    #1 chk("hold_stall_cnt", 64'(stall_cnt), 64'd1);
    chk("hold_flush_cnt", 64'(flush_cnt), 64'd1);
    step(1, 5'd1, 1, 5'd0, 0, 5'd14, 1, 0, 0, 0, 0);

    // 20 load-use stalls; 4-bit counter saturates
    repeat (20) begin
      step(1, 5'd1, 0, 5'd0, 0, 5'd12, 1, 1, 0, 0, 0);
      step(1, 5'd12, 1, 5'd0, 0, 5'd16, 1, 0, 0, 0, 0);
      step(1, 5'd12, 1, 5'd0, 0, 5'd16, 1, 0, 0, 0, 0);
    end
    #1 chk("stall_cnt_21", 64'(stall_cnt), 64'd21);
    chk("sat_cnt_15", 64'(s_stall_cnt), 64'd15);

    // reset mid-stream with full pipeline
    step(1, 5'd1, 1, 5'd0, 0, 5'd17, 1, 0, 0, 0, 1);
    #1 chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    step(1, 5'd16, 1, 5'd16, 1, 5'd18, 1, 0, 0, 0, 0);
    chk("rst_sel1", 64'(last_sel1), 64'd0);

    // random traffic on a small register set
    repeat (400) begin
      step(($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
           5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
